// File: rtl/fc_fm_pingpong_buffer_if.sv
// Byte-stream input and classifier-facing signals of the feature-map ping-pong buffer.
// slave = buffer side, master = producer/classifier side.
interface fc_fm_pingpong_buffer_if;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic [15:0] i_fc_fm_addr;
  logic [63:0] o_fc_fm_data;
  logic [8:0]  o_fc_fm_base_addr;
  logic        o_fc_start;
  logic        i_fc_result_valid;
  logic        o_busy;
  logic [1:0]  o_bank_full;

  modport slave (
    input  s_valid, s_data, i_fc_fm_addr, i_fc_result_valid,
    output s_ready, o_fc_fm_data, o_fc_fm_base_addr, o_fc_start, o_busy, o_bank_full
  );

  modport master (
    output s_valid, s_data, i_fc_fm_addr, i_fc_result_valid,
    input  s_ready, o_fc_fm_data, o_fc_fm_base_addr, o_fc_start, o_busy, o_bank_full
  );
endinterface

// File: rtl/fc_fm_pingpong_buffer.sv
// Packs an int8 activation stream into two 64-bit banks and launches the FC classifier
// on each full bank; a bank is freed on the rising edge of the classifier's result-valid.
module fc_fm_pingpong_buffer #(
  parameter int FEAT_BYTES = 384,
  parameter int BANK1_BASE = 384
) (
  input logic                   clk,
  input logic                   rst_n,
  fc_fm_pingpong_buffer_if.slave bus
);
  localparam int WORDS = FEAT_BYTES / 8;
  localparam int IDXW  = $clog2(2 * WORDS);
  localparam int WCW   = $clog2(WORDS);
  localparam logic [WCW-1:0] LAST_WORD = WCW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, START, BUSY} state_t;

  state_t            r_state, w_state_nxt;
  logic [2:0]        r_lane;
  logic [WCW-1:0]    r_word_cnt;
  logic              r_wr_bank, r_rd_bank;
  logic [1:0]        r_bank_full;
  logic [55:0]       r_shreg;
  logic [63:0]       r_mem [2*WORDS];
  logic [63:0]       r_rd_data;
  logic              r_start, r_busy, r_rv_prev;
  logic [8:0]        r_base;

  logic              w_ready, w_accept, w_word_done, w_img_done, w_release;
  logic [IDXW-1:0]   w_wr_idx;
  logic [15:0]       w_rd_word;
  logic              w_rd_hit;
  logic [1:0]        w_set, w_clr;

  assign w_ready     = !r_bank_full[r_wr_bank];
  assign w_accept    = bus.s_valid && w_ready;
  assign w_word_done = w_accept && (r_lane == 3'd7);
  assign w_img_done  = w_word_done && (r_word_cnt == LAST_WORD);
  // Only a genuine low->high transition while running releases the bank.
  assign w_release   = (r_state == BUSY) && bus.i_fc_result_valid && !r_rv_prev;
  assign w_wr_idx    = IDXW'(r_word_cnt) + (r_wr_bank ? IDXW'(WORDS) : IDXW'(0));
  assign w_rd_word   = bus.i_fc_fm_addr >> 3;
  assign w_rd_hit    = w_rd_word < 16'(2 * WORDS);
  assign w_set       = w_img_done ? (r_wr_bank ? 2'b10 : 2'b01) : 2'b00;
  assign w_clr       = w_release  ? (r_rd_bank ? 2'b10 : 2'b01) : 2'b00;

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (w_word_done) r_mem[w_wr_idx] <= {bus.s_data, r_shreg};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lane     <= '0;
      r_word_cnt <= '0;
      r_wr_bank  <= 1'b0;
      r_shreg    <= '0;
    end else if (w_accept) begin
      if (r_lane == 3'd7) begin
        r_lane <= '0;
        if (w_img_done) begin
          r_word_cnt <= '0;
          r_wr_bank  <= ~r_wr_bank;
        end else begin
          r_word_cnt <= r_word_cnt + 1'b1;
        end
      end else begin
        r_shreg[{r_lane, 3'b000} +: 8] <= bus.s_data;
        r_lane <= r_lane + 1'b1;
      end
    end
  end

  // Set and clear always hit different banks, so both may land on one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bank_full <= '0;
      r_rd_bank   <= 1'b0;
      r_rv_prev   <= 1'b0;
    end else begin
      r_bank_full <= (r_bank_full | w_set) & ~w_clr;
      r_rv_prev   <= bus.i_fc_result_valid;
      if (w_release) r_rd_bank <= ~r_rd_bank;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (r_bank_full[r_rd_bank]) w_state_nxt = START;
      START:   w_state_nxt = BUSY;
      BUSY:    if (w_release) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_start   <= 1'b0;
      r_busy    <= 1'b0;
      r_base    <= '0;
      r_rd_data <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_start   <= (w_state_nxt == START);
      r_busy    <= (w_state_nxt == START) || (w_state_nxt == BUSY);
      r_base    <= r_rd_bank ? 9'(BANK1_BASE) : 9'd0;
      r_rd_data <= w_rd_hit ? r_mem[w_rd_word[IDXW-1:0]] : 64'h0;
    end
  end

  assign bus.s_ready           = w_ready;
  assign bus.o_fc_fm_data      = r_rd_data;
  assign bus.o_fc_fm_base_addr = r_base;
  assign bus.o_fc_start        = r_start;
  assign bus.o_busy            = r_busy;
  assign bus.o_bank_full       = r_bank_full;
endmodule

// File: tb/tb_fc_fm_pingpong_buffer.sv
// Self-checking bench: byte-level reference model of both banks plus directed sequences
// for launch/release/reset corners.
module tb_fc_fm_pingpong_buffer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fc_fm_pingpong_buffer_if bus();
  fc_fm_pingpong_buffer dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;
  int n_start = 0;

  // Reference model: image bytes laid out at bank*384 + offset, plus bank ownership flags.
  logic [7:0] exp_mem [0:767];
  bit         m_full [2];
  bit         m_wbank, m_rbank;
  int         m_cnt;

  typedef struct {
    logic [15:0] addr;
    logic [63:0] exp;
  } vec_t;
  vec_t vt [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (bus.o_fc_start) n_start++;
  endtask

  function automatic logic [1:0] mfull();
    return {m_full[1], m_full[0]};
  endfunction

  function automatic logic [63:0] model_word(input int addr);
    int idx;
    logic [63:0] w;
    idx = addr >> 3;
    w = '0;
    if (idx >= 96) return 64'h0;
    for (int i = 0; i < 8; i++) w[8*i +: 8] = exp_mem[idx*8 + i];
    return w;
  endfunction

  task automatic model_reset();
    m_full[0] = 0; m_full[1] = 0;
    m_wbank = 0; m_rbank = 0; m_cnt = 0;
  endtask

  task automatic model_accept(input logic [7:0] b);
    exp_mem[(m_wbank ? 384 : 0) + m_cnt] = b;
    m_cnt++;
    if (m_cnt == 384) begin
      m_cnt = 0;
      m_full[m_wbank] = 1;
      m_wbank = !m_wbank;
    end
  endtask

  task automatic model_release();
    m_full[m_rbank] = 0;
    m_rbank = !m_rbank;
  endtask

  task automatic send(input logic [7:0] b);
    bus.s_valid = 1'b1;
    bus.s_data  = b;
    for (int n = 0; n < 100; n++) begin
      if (bus.s_ready) begin
        chk("s_ready_model", {63'b0, bus.s_ready}, {63'b0, !m_full[m_wbank]});
        tick();
        bus.s_valid = 1'b0;
        model_accept(b);
        return;
      end
      tick();
    end
    bus.s_valid = 1'b0;
    chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic read(input int addr, input string name);
    bus.i_fc_fm_addr = 16'(addr);
    tick();
    chk(name, bus.o_fc_fm_data, model_word(addr));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_bank_full"}, {62'b0, bus.o_bank_full}, 64'd0);
    chk({tag, "_start"},     {63'b0, bus.o_fc_start},  64'd0);
    chk({tag, "_busy"},      {63'b0, bus.o_busy},      64'd0);
    chk({tag, "_data"},      bus.o_fc_fm_data,         64'd0);
    chk({tag, "_base"},      {55'b0, bus.o_fc_fm_base_addr}, 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vt[0] = '{16'd8,     64'h0F0E0D0C0B0A0908};
    vt[1] = '{16'd13,    64'h0F0E0D0C0B0A0908};
    vt[2] = '{16'd0,     64'h0706050403020100};
    vt[3] = '{16'd376,   64'h7F7E7D7C7B7A7978};
    vt[4] = '{16'd383,   64'h7F7E7D7C7B7A7978};
    vt[5] = '{16'd800,   64'h0};
    vt[6] = '{16'hFFFF,  64'h0};

    bus.s_valid = 1'b0;
    bus.s_data = 8'h0;
    bus.i_fc_fm_addr = 16'h0;
    bus.i_fc_result_valid = 1'b0;
    model_reset();

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    tick();
    chk("ready_after_reset", {63'b0, bus.s_ready}, 64'd1);

    // Image 0: contiguous k mod 256
    for (int k = 0; k < 384; k++) send(8'(k));
    chk("img0_bank_full", {62'b0, bus.o_bank_full}, 64'd1);
    chk("img0_start_not_yet", {63'b0, bus.o_fc_start}, 64'd0);
    tick();
    chk("img0_start", {63'b0, bus.o_fc_start}, 64'd1);
    chk("img0_busy",  {63'b0, bus.o_busy}, 64'd1);
    chk("img0_base",  {55'b0, bus.o_fc_fm_base_addr}, 64'd0);
    tick();
    chk("img0_start_one_cycle", {63'b0, bus.o_fc_start}, 64'd0);
    chk("img0_busy_hold", {63'b0, bus.o_busy}, 64'd1);

    for (int i = 0; i < 7; i++) begin
      bus.i_fc_fm_addr = vt[i].addr;
      tick();
      chk($sformatf("vec%0d_table", i), bus.o_fc_fm_data, vt[i].exp);
      chk($sformatf("vec%0d_model", i), bus.o_fc_fm_data, model_word(int'(vt[i].addr)));
    end

    // Image 1 while busy: fills bank 1, writer then stalls on bank 0
    for (int k = 0; k < 384; k++) send(8'hA5);
    chk("img1_bank_full", {62'b0, bus.o_bank_full}, 64'd3);
    chk("img1_model_full", {62'b0, bus.o_bank_full}, {62'b0, mfull()});
    chk("img1_ready_low", {63'b0, bus.s_ready}, 64'd0);
    bus.s_valid = 1'b1;
    bus.s_data = 8'h33;
    repeat (4) begin
      tick();
      chk("stall_ready", {63'b0, bus.s_ready}, 64'd0);
    end
    bus.s_valid = 1'b0;
    bus.i_fc_fm_addr = 16'd384;
    tick();
    chk("bank1_word0", bus.o_fc_fm_data, 64'hA5A5A5A5A5A5A5A5);
    read(760, "bank1_last");
    read(8, "bank0_intact");

    // Release bank 0; bank 1 relaunches after the IDLE cycle
    bus.i_fc_result_valid = 1'b1;
    tick();
    bus.i_fc_result_valid = 1'b0;
    model_release();
    chk("rel0_bank_full", {62'b0, bus.o_bank_full}, 64'd2);
    chk("rel0_ready", {63'b0, bus.s_ready}, 64'd1);
    chk("rel0_busy", {63'b0, bus.o_busy}, 64'd0);
    tick();
    chk("relaunch_start", {63'b0, bus.o_fc_start}, 64'd1);
    chk("relaunch_base", {55'b0, bus.o_fc_fm_base_addr}, 64'd384);
    tick();
    chk("relaunch_start_one", {63'b0, bus.o_fc_start}, 64'd0);

    // Release bank 1, then keep result-valid high through the next launch
    bus.i_fc_result_valid = 1'b1;
    tick();
    model_release();
    chk("rel1_bank_full", {62'b0, bus.o_bank_full}, {62'b0, mfull()});
    chk("rel1_busy", {63'b0, bus.o_busy}, 64'd0);

    // Random 50% duty image into bank 0
    n_start = 0;
    for (int k = 0; k < 384; k++) begin
      if ($urandom_range(1, 0) == 1) tick();
      send(8'($urandom));
    end
    repeat (4) tick();
    chk("rand_one_start", 64'(n_start), 64'd1);
    chk("hold_busy", {63'b0, bus.o_busy}, 64'd1);
    chk("hold_bank_full", {62'b0, bus.o_bank_full}, 64'd1);
    chk("rand_base", {55'b0, bus.o_fc_fm_base_addr}, 64'd0);
    for (int w = 0; w < 48; w++) read(w * 8, $sformatf("rand_word%0d", w));
    bus.i_fc_result_valid = 1'b0;
    tick();
    chk("hold_fall_no_release", {62'b0, bus.o_bank_full}, 64'd1);
    chk("hold_fall_busy", {63'b0, bus.o_busy}, 64'd1);
    bus.i_fc_result_valid = 1'b1;
    tick();
    bus.i_fc_result_valid = 1'b0;
    model_release();
    chk("hold_rise_release", {62'b0, bus.o_bank_full}, {62'b0, mfull()});
    chk("hold_rise_busy", {63'b0, bus.o_busy}, 64'd0);

    // Reset after 200 bytes of a partial image
    for (int k = 0; k < 200; k++) send(8'(k * 3 + 1));
    bus.i_fc_fm_addr = 16'd384;
    tick();
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midfill");
    model_reset();
    tick();
    rst_n = 1'b1;
    tick();

    // Fresh image after reset restarts at lane 0 of bank 0
    for (int k = 0; k < 384; k++) send(8'(k) ^ 8'h5A);
    chk("img4_bank_full", {62'b0, bus.o_bank_full}, 64'd1);
    bus.i_fc_fm_addr = 16'd0;
    tick();
    chk("img4_word0", bus.o_fc_fm_data, 64'h5D5C5F5E59585B5A);
    chk("img4_word0_model", bus.o_fc_fm_data, model_word(0));
    read(200, "img4_word25");
    tick();
    chk("img4_busy", {63'b0, bus.o_busy}, 64'd1);

    // Reset in the middle of a classifier run
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midbusy");
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_reset_ready", {63'b0, bus.s_ready}, 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
